// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment type, glyph table and capture FSM states.
// Encoder and decoder both index SEG7_GLYPH so the two directions stay consistent.
package seg7_pkg;

    typedef logic [6:0] seg7_t;  // {g,f,e,d,c,b,a}, active-high

    localparam seg7_t SEG7_BLANK = 7'h00;

    localparam seg7_t SEG7_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        SETTLE = 1'b0,
        HELD   = 1'b1
    } capture_state_t;

    function automatic seg7_t seg7_encode(input logic [3:0] nibble);
        return SEG7_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seg7_to_bin.sv
// Combinational inverse of the glyph table: segment pattern -> hex nibble.
// Patterns outside the table (including blank) report glyph_valid_o = 0.
module seg7_to_bin
    import seg7_pkg::*;
(
    input  seg7_t      seg_i,
    output logic [3:0] nibble_o,
    output logic       glyph_valid_o
);

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        nibble_o      = 4'h0;
        glyph_valid_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG7_GLYPH[i]) begin
                nibble_o      = 4'(i);
                glyph_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// Receive side of a multiplexed 7-segment display: synchronises the scan lines,
// waits for each digit to settle, decodes it and emits one word per complete frame.
module seven_seg_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              segments_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel_in,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic                    value_valid_out,
    output logic                    pattern_error_out
);

    localparam int         SAMPLE_W = NUM_DIGITS + 7;
    localparam int         IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    seg7_t                   seg_meta_q, seg_sync_q;
    logic [NUM_DIGITS-1:0]   sel_meta_q, sel_sync_q;
    logic [SAMPLE_W-1:0]     prev_q;
    logic [7:0]              stab_cnt_q;
    capture_state_t          state_q;

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic [SAMPLE_W-1:0]     sample;
    logic                    same;
    logic                    settle_hit;
    logic                    evaluate;
    logic [IDX_W-1:0]        sel_idx;
    logic [3:0]              nibble;
    logic                    glyph_valid;

    seg7_to_bin u_decode (
        .seg_i        (seg_sync_q),
        .nibble_o     (nibble),
        .glyph_valid_o(glyph_valid)
    );

    assign sample     = {sel_sync_q, seg_sync_q};
    assign same       = (sample == prev_q);
    assign settle_hit = (state_q == SETTLE) && same && (stab_cnt_q == CNT_LAST);
    // Only a single selected, non-blank digit is worth decoding.
    assign evaluate   = settle_hit && $onehot(sel_sync_q) && (seg_sync_q != SEG7_BLANK);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_sync_q[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        seen_d   = seen_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        err_d    = evaluate && !glyph_valid;
        if (evaluate && glyph_valid) begin
            shadow_d[4*sel_idx +: 4] = nibble;
            seen_d[sel_idx]          = 1'b1;
            if (&seen_d) begin
                value_d = shadow_d;
                seen_d  = '0;
                valid_d = 1'b1;
            end
        end
    end

    // NOTE: the partial-frame shadow is flop-based and cleared on reset so a
    // reset mid-frame cannot leak stale nibbles into the next reported word.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta_q <= '0;
            seg_sync_q <= '0;
            sel_meta_q <= '0;
            sel_sync_q <= '0;
            prev_q     <= '0;
            stab_cnt_q <= '0;
            state_q    <= SETTLE;
            shadow_q   <= '0;
            seen_q     <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            seg_meta_q <= segments_in;
            seg_sync_q <= seg_meta_q;
            sel_meta_q <= digit_sel_in;
            sel_sync_q <= sel_meta_q;
            prev_q     <= sample;
            shadow_q   <= shadow_d;
            seen_q     <= seen_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            err_q      <= err_d;

            case (state_q)
                SETTLE: begin
                    if (!same) begin
                        stab_cnt_q <= '0;
                    end else if (settle_hit) begin
                        state_q <= HELD;
                    end else if (stab_cnt_q != 8'hFF) begin
                        stab_cnt_q <= stab_cnt_q + 8'd1;
                    end
                end
                HELD: begin
                    if (!same) begin
                        stab_cnt_q <= '0;
                        state_q    <= SETTLE;
                    end
                end
                default: state_q <= SETTLE;
            endcase
        end
    end

    assign value_out         = value_q;
    assign value_valid_out   = valid_q;
    assign pattern_error_out = err_q;

endmodule

// File: doc/seven_seg_scan_capture.md
Name: seven_seg_scan_capture

Overview:
- Receive side of the multiplexed 7-segment display interface.
- Samples the scanned segment and digit-select lines that drive a display, waits for each digit's pattern to settle, and inverts the {g..a} segment encoding back to a hex nibble.
- Assembles one full frame of NUM_DIGITS nibbles and presents it as a parallel word with a one-cycle valid strobe.
- Used for loopback self-test of the frequency-counter display path and for reading external 7-seg displays.

Parameters:
- NUM_DIGITS, 4: number of scanned digits; value width is 4*NUM_DIGITS.
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted; legal range 2..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- segments_in  in  7  segment lines {g,f,e,d,c,b,a}, active-high; asynchronous to clk.
- digit_sel_in  in  NUM_DIGITS  digit enables, one-hot, active-high, bit 0 = least-significant digit; asynchronous to clk.
- value_out  out  4*NUM_DIGITS  last complete frame; digit i occupies bits [4i+3:4i].
- value_valid_out  out  1  one-cycle pulse when value_out updates.
- pattern_error_out  out  1  one-cycle pulse when a settled, selected pattern is not a legal hex glyph.

Behaviour:
- Reset (async assert, sync deassert by the system) clears these to 0:
  - value_out, value_valid_out, pattern_error_out;
  - synchronisers, stability counter, shadow nibbles, seen mask;
  - FSM, which returns to SETTLE.
- Input path:
  - segments_in and digit_sel_in each pass through a 2-FF synchroniser.
  - Sample s = {sel_sync, seg_sync}; prev holds the previous cycle's s.
- FSM states:
  - SETTLE: if s != prev, stab_cnt <= 0. Else stab_cnt increments, saturating. When stab_cnt reaches STABLE_CYCLES-1 with s == prev, the sample is evaluated that cycle and the FSM goes to HELD.
  - HELD: the sample has been consumed. Any s != prev sets stab_cnt <= 0 and returns to SETTLE. A held digit is evaluated exactly once, however long it stays.
- Evaluation of a settled sample:
  - sel not one-hot (zero or more than one bit): ignored; no error, no seen update.
  - seg == 7'h00 (blanked): ignored; no error.
  - seg is a legal glyph: shadow[idx] <= nibble, seen[idx] <= 1.
  - Otherwise: pattern_error_out pulses the next cycle; seen[idx] is left unchanged.
- Glyph table, nibble:pattern:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, B:7C, C:39, D:5E, E:79, F:71
- Frame completion:
  - When the update makes seen all-ones, the next cycle: value_out <= shadow (including the just-written nibble), value_valid_out = 1 for one cycle, seen <= 0.
- Digit revisits: a digit seen again before the frame completes overwrites its shadow nibble. Last write wins.
- Latency: last input edge -> value_valid_out = 2 (sync) + STABLE_CYCLES + 1 cycles.
- Outputs are registered. value_out holds between frames.
- Reset mid-frame discards all partial shadow and seen state.

Decomposition:
- Package seg7_pkg:
  - typedef seg7_t (logic [6:0], {g..a});
  - localparam array SEG7_GLYPH[16] with the table above;
  - SEG7_BLANK = 7'h00;
  - FSM enum capture_state_t {SETTLE, HELD}.
- Sub-module seg7_to_bin: combinational inverse lookup.
  - Input seg7_t.
  - Outputs nibble[3:0] and glyph_valid.
  - Shares SEG7_GLYPH with the forward encoder so the two directions cannot diverge.

Test Plan:
- Settled frame: NUM_DIGITS=4, STABLE_CYCLES=4, scan sel 0001..1000 with glyphs 4F, 5B, 06, 3F for 8 cycles each -> exactly one value_valid_out pulse; value_out = 16'h0123.
- Glitch rejection: hold digit 0 = 6D but toggle seg to 7D for 2 cycles every 3 cycles -> no acceptance while toggling. After 4 stable cycles of 6D, nibble 5 is accepted once (check via completed frame).
- Illegal glyph: sel=0010, seg=7'h49 held 10 cycles -> pattern_error_out pulses exactly once. That frame does not complete until digit 1 later shows a legal glyph.
- Blank and non-one-hot: seg=00 on any digit, or sel=0000 / 0011 with any seg, for 20 cycles -> no error pulse, no seen change, value_out unchanged.
- Overwrite and latency: digits 0..2 = A, B, C; digit 0 rewritten to E; then digit 3 = F -> value_out = 16'hFCBE. Pulse occurs 2+4+1 = 7 cycles after digit 3's final input edge.
- Reset mid-frame: assert rst after 3 of 4 digits captured, then scan a fresh frame 8,9,A,B -> only value_out = 16'hBA98 is reported; no stale nibbles; all outputs read 0 while rst is high.
